// File: rtl/sopc_bus_pkg.sv
// sopc_bus_pkg: shared definitions for the SoC memory-bus arbiter.
//   - bus_state_e : arbiter FSM state encoding (idle / busy / response)
//   - DefAddrW, DefDataW, DefMaskW : default bus geometry
//   - idx_w()     : width of a master index for a given master count
package sopc_bus_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } bus_state_e;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefMaskW = DefDataW / 8;

    // A single master still needs a 1-bit index so the vectors stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       in  N   request vector
//   ptr       in  IW  index with highest priority this round
//   grant_idx out IW  first requester at or after ptr, wrapping modulo N
//   any       out 1   at least one request is present
module rr_arbiter
    import sopc_bus_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // Scan from furthest to nearest so the requester closest to ptr wins last.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % int'(N)]) begin
                grant_idx = IW'((int'(ptr) + k) % int'(N));
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sopc_bus_arbiter.sv
// sopc_bus_arbiter: N-master to 1-slave memory bus arbiter, round-robin.
//   clk, rst            clock, synchronous active-high reset
//   m_req/m_we/m_addr/m_wdata/m_mask  packed per-master request fields
//   m_rdata, m_ready, m_err           registered response (one-hot ready pulse)
//   s_req/s_we/s_addr/s_wdata/s_mask  registered slave request, held until s_ready
//   s_rdata, s_ready                  slave response
// Access sequence: IDLE (arbitrate) -> BUSY (slave access) -> RESP (ready pulse).
module sopc_bus_arbiter
    import sopc_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned MASK_W      = DefMaskW,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*MASK_W-1:0] m_mask,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic                          m_err,
    output logic                          s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [MASK_W-1:0]             s_mask,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready
);

    localparam int unsigned IW   = idx_w(NUM_MASTERS);
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    bus_state_e      state_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   grant_q;
    logic [CntW-1:0] cnt_q;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;
    logic            timeout_hit;

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (m_req),
        .ptr       (rr_ptr_q),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    if (TIMEOUT != 0) begin : g_timeout
        assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
    end else begin : g_no_timeout
        assign timeout_hit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            m_rdata  <= '0;
            m_ready  <= '0;
            m_err    <= 1'b0;
            s_req    <= 1'b0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_mask   <= '0;
        end else begin
            // Response outputs are single-cycle pulses; only the BUSY exit sets them.
            m_ready <= '0;
            m_err   <= 1'b0;
            m_rdata <= '0;
            unique case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        grant_q <= arb_idx;
                        s_req   <= 1'b1;
                        s_we    <= m_we[arb_idx];
                        s_addr  <= m_addr[arb_idx*ADDR_W +: ADDR_W];
                        s_wdata <= m_wdata[arb_idx*DATA_W +: DATA_W];
                        s_mask  <= m_mask[arb_idx*MASK_W +: MASK_W];
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (s_ready) begin
                        s_req            <= 1'b0;
                        m_ready[grant_q] <= 1'b1;
                        m_rdata          <= s_we ? '0 : s_rdata;
                        state_q          <= StResp;
                    end else if (timeout_hit) begin
                        s_req            <= 1'b0;
                        m_ready[grant_q] <= 1'b1;
                        m_err            <= 1'b1;
                        state_q          <= StResp;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    // Old request is still asserted here; arbitration resumes next cycle.
                    rr_ptr_q <= (grant_q == IW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_bus_arbiter.sv
module tb_sopc_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [1:0]  m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_mask;
    logic [31:0] m_rdata;
    logic [1:0]  m_ready;
    logic        m_err;
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_mask;
    logic [31:0] s_rdata;
    logic        s_ready;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sopc_bus_arbiter #(
        .NUM_MASTERS (2),
        .ADDR_W      (32),
        .DATA_W      (32),
        .MASK_W      (4),
        .TIMEOUT     (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_mask  (m_mask),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_mask  (s_mask),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst     = 1'b1;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_mask  = '0;
        s_rdata = '0;
        s_ready = 1'b0;
        tick();
        tick();
        check("rst_s_req", 64'(s_req), 64'd0);
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_m_err", 64'(m_err), 64'd0);
        check("rst_m_rdata", 64'(m_rdata), 64'd0);

        // 1: single zero-wait read from master 0
        rst           = 1'b0;
        m_req         = 2'b01;
        m_addr[31:0]  = 32'h8000_0000;
        s_rdata       = 32'h1234_5678;
        tick();                                   // cycle 1
        check("t1_s_req", 64'(s_req), 64'd1);
        check("t1_s_addr", 64'(s_addr), 64'h8000_0000);
        check("t1_s_we", 64'(s_we), 64'd0);
        check("t1_no_ready_c1", 64'(m_ready), 64'd0);
        s_ready = 1'b1;
        tick();                                   // cycle 2
        check("t1_m_ready", 64'(m_ready), 64'b01);
        check("t1_m_rdata", 64'(m_rdata), 64'h1234_5678);
        check("t1_m_err", 64'(m_err), 64'd0);
        check("t1_s_req_low", 64'(s_req), 64'd0);
        s_ready = 1'b0;
        tick();                                   // cycle 3, request still held through RESP
        check("t1_ready_pulse", 64'(m_ready), 64'd0);
        check("t1_no_rearb", 64'(s_req), 64'd0);
        m_req = 2'b00;
        tick();
        check("t1_idle", 64'(s_req), 64'd0);

        // 2: simultaneous requests right after reset
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        m_req         = 2'b11;
        m_addr[31:0]  = 32'h0000_0100;
        m_addr[63:32] = 32'h0000_0200;
        s_rdata       = 32'h0000_00A0;
        s_ready       = 1'b1;
        tick();                                   // c1
        check("t2_first_addr", 64'(s_addr), 64'h100);
        tick();                                   // c2
        check("t2_ready0", 64'(m_ready), 64'b01);
        check("t2_rdata0", 64'(m_rdata), 64'hA0);
        tick();                                   // c3
        m_req   = 2'b10;
        tick();                                   // c4
        check("t2_second_addr", 64'(s_addr), 64'h200);
        s_rdata = 32'h0000_00B1;
        tick();                                   // c5
        check("t2_ready1", 64'(m_ready), 64'b10);
        check("t2_rdata1", 64'(m_rdata), 64'hB1);
        tick();                                   // c6

        // 3: both masters re-request continuously; grants alternate from master 0
        m_req = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();                               // BUSY
            check("t3_addr", 64'(s_addr), (i % 2 == 0) ? 64'h100 : 64'h200);
            tick();                               // RESP
            check("t3_ready", 64'(m_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            tick();                               // IDLE
        end
        m_req   = 2'b00;
        s_ready = 1'b0;

        // 4: write from master 1 with 5 wait cycles
        m_req          = 2'b10;
        m_we           = 2'b10;
        m_addr[63:32]  = 32'h0000_0040;
        m_wdata[63:32] = 32'hAABB_CCDD;
        m_mask[7:4]    = 4'b0011;
        s_rdata        = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_s_req", 64'(s_req), 64'd1);
            check("t4_s_we", 64'(s_we), 64'd1);
            check("t4_s_addr", 64'(s_addr), 64'h40);
            check("t4_s_wdata", 64'(s_wdata), 64'hAABB_CCDD);
            check("t4_s_mask", 64'(s_mask), 64'b0011);
            check("t4_no_ready", 64'(m_ready), 64'd0);
            if (k == 4) s_ready = 1'b1;
        end
        tick();
        check("t4_m_ready", 64'(m_ready), 64'b10);
        check("t4_m_rdata_zero", 64'(m_rdata), 64'd0);
        check("t4_m_err", 64'(m_err), 64'd0);
        s_ready = 1'b0;
        tick();
        m_req = 2'b00;
        m_we  = 2'b00;

        // 5: timeout on master 0, then master 0 served normally
        m_req        = 2'b01;
        m_addr[31:0] = 32'h0000_0300;
        s_rdata      = 32'hFFFF_FFFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t5_busy_s_req", 64'(s_req), 64'd1);
            check("t5_busy_no_ready", 64'(m_ready), 64'd0);
        end
        tick();                                   // 9 cycles after grant
        check("t5_m_ready", 64'(m_ready), 64'b01);
        check("t5_m_err", 64'(m_err), 64'd1);
        check("t5_m_rdata", 64'(m_rdata), 64'd0);
        tick();
        check("t5_err_pulse", 64'(m_err), 64'd0);
        m_addr[31:0] = 32'h0000_0500;
        s_rdata      = 32'h5555_AAAA;
        s_ready      = 1'b1;
        tick();
        check("t5_next_addr", 64'(s_addr), 64'h500);
        tick();
        check("t5_next_ready", 64'(m_ready), 64'b01);
        check("t5_next_rdata", 64'(m_rdata), 64'h5555_AAAA);
        check("t5_next_err", 64'(m_err), 64'd0);
        s_ready = 1'b0;
        tick();
        m_req = 2'b00;

        // 6: reset during BUSY aborts; pointer returns to master 0
        m_req         = 2'b10;
        m_addr[31:0]  = 32'h0000_0700;
        m_addr[63:32] = 32'h0000_0600;
        tick();
        check("t6_busy", 64'(s_req), 64'd1);
        check("t6_busy_addr", 64'(s_addr), 64'h600);
        rst = 1'b1;
        tick();
        check("t6_s_req_cleared", 64'(s_req), 64'd0);
        check("t6_no_ready", 64'(m_ready), 64'd0);
        rst     = 1'b0;
        m_req   = 2'b11;
        s_rdata = 32'h0BAD_F00D;
        s_ready = 1'b1;
        tick();
        check("t6_ptr_reset_addr", 64'(s_addr), 64'h700);
        check("t6_still_no_ready", 64'(m_ready), 64'd0);
        tick();
        check("t6_fresh_ready", 64'(m_ready), 64'b01);
        check("t6_fresh_rdata", 64'(m_rdata), 64'h0BAD_F00D);
        m_req   = 2'b00;
        s_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Absolute bound so the run ends even if the sequence stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
